// File: rtl/codec_i2s_slave_if.sv
// Parallel-side bus of the I2S slave: the ADC sample pair with its valid
// strobe, the DAC pair with its ready/valid handshake, and the status pulses.
interface codec_i2s_slave_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] oADC_L;
  logic [DATA_WIDTH-1:0] oADC_R;
  logic                  oADC_VALID;
  logic [DATA_WIDTH-1:0] iDAC_L;
  logic [DATA_WIDTH-1:0] iDAC_R;
  logic                  iDAC_VALID;
  logic                  oDAC_READY;
  logic                  oUNDERRUN;
  logic                  oFRAME_ERR;

  // Audio sample producer/consumer side
  modport master (
    input  oADC_L, oADC_R, oADC_VALID, oDAC_READY, oUNDERRUN, oFRAME_ERR,
    output iDAC_L, iDAC_R, iDAC_VALID
  );

  // I2S block side
  modport slave (
    output oADC_L, oADC_R, oADC_VALID, oDAC_READY, oUNDERRUN, oFRAME_ERR,
    input  iDAC_L, iDAC_R, iDAC_VALID
  );
endinterface

// File: rtl/codec_i2s_slave.sv
// I2S slave interface for a WM8731 running as I2S master. BCLK, LRCK and
// ADCDAT are oversampled in the 18.432 MHz domain; BCLK is data, never a clock.
//
// RX state | meaning
// ---------+-------------------------------------------------------------
// RX_IDLE  | after reset, waiting for the first delay slot
// RX_SHIFT | shifting a channel word in MSB-first, bit_cnt 0..DATA_WIDTH-1
// RX_WAIT  | word stored, ignoring extra slot bits until the next delay slot
module codec_i2s_slave #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               iCLK_18_4,
  input  logic               iRST_N,
  input  logic               iAUD_BCK,
  input  logic               iAUD_LRCK,
  input  logic               iAUD_ADCDAT,
  output logic               oAUD_DACDAT,
  codec_i2s_slave_if.slave   bus
);

  // Fewer than two stages would not be a synchronizer, so clamp at two.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_WAIT  = 2'd2
  } rx_state_e;

  // Input synchronizers and edge/slot detection
  logic [SYNC_N-1:0] bck_sync_q;
  logic [SYNC_N-1:0] lr_sync_q;
  logic [SYNC_N-1:0] adc_sync_q;
  logic              bck_prev_q;
  logic              lr_prev_q;
  logic              lr_vld_q;
  logic              bck_s;
  logic              lr_s;
  logic              adc_s;
  logic              bck_rise;
  logic              slot;
  logic              left_slot;
  logic              right_slot;

  // RX datapath
  rx_state_e             rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  chan_q, chan_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  left_ok_q, left_ok_d;
  logic [DATA_WIDTH-1:0] adc_l_q, adc_l_d;
  logic [DATA_WIDTH-1:0] adc_r_q, adc_r_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] word_done;

  // TX datapath
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic                  hold_full_q, hold_full_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] tx_right_q, tx_right_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                  dacdat_q, dacdat_d;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] tx_word;
  logic                  accept;

  assign bck_s    = bck_sync_q[SYNC_N-1];
  assign lr_s     = lr_sync_q[SYNC_N-1];
  assign adc_s    = adc_sync_q[SYNC_N-1];
  assign bck_rise = bck_s & ~bck_prev_q;
  // lr_prev is meaningless until one BCLK rise has been seen after reset;
  // without the qualifier a high LRCK at reset release would fake a slot.
  assign slot       = bck_rise & lr_vld_q & (lr_s ^ lr_prev_q);
  assign left_slot  = slot & ~lr_s;
  assign right_slot = slot & lr_s;
  assign word_done  = {shift_q[DATA_WIDTH-2:0], adc_s};
  assign accept     = bus.iDAC_VALID & ready_q;

  // Synchronize the codec pins and track BCLK/LRCK history
  always_ff @(posedge iCLK_18_4) begin
    if (!iRST_N) begin
      bck_sync_q <= '0;
      lr_sync_q  <= '0;
      adc_sync_q <= '0;
      bck_prev_q <= 1'b0;
      lr_prev_q  <= 1'b0;
      lr_vld_q   <= 1'b0;
    end else begin
      bck_sync_q <= {bck_sync_q[SYNC_N-2:0], iAUD_BCK};
      lr_sync_q  <= {lr_sync_q[SYNC_N-2:0], iAUD_LRCK};
      adc_sync_q <= {adc_sync_q[SYNC_N-2:0], iAUD_ADCDAT};
      bck_prev_q <= bck_s;
      if (bck_rise) begin
        lr_prev_q <= lr_s;
        lr_vld_q  <= 1'b1;
      end
    end
  end

  // RX next-state: deserialize on BCLK rises, pair left/right into a valid
  always_comb begin
    rx_state_d  = rx_state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    chan_d      = chan_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    adc_l_d     = adc_l_q;
    adc_r_d     = adc_r_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    if (bck_rise) begin
      case (rx_state_q)
        RX_IDLE, RX_WAIT: begin
          if (slot) begin
            rx_state_d = RX_SHIFT;
            bit_cnt_d  = '0;
            chan_d     = lr_s;
          end
        end
        RX_SHIFT: begin
          if (slot) begin
            // Short word: drop it and poison the pairing for this frame.
            ferr_d    = 1'b1;
            left_ok_d = 1'b0;
            bit_cnt_d = '0;
            chan_d    = lr_s;
          end else begin
            shift_d   = word_done;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              rx_state_d = RX_WAIT;
              if (!chan_q) begin
                left_hold_d = word_done;
                left_ok_d   = 1'b1;
              end else begin
                adc_r_d   = word_done;
                left_ok_d = 1'b0;
                if (left_ok_q) begin
                  adc_l_d = left_hold_q;
                  valid_d = 1'b1;
                end
              end
            end
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // RX state and output registers
  always_ff @(posedge iCLK_18_4) begin
    if (!iRST_N) begin
      rx_state_q  <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      chan_q      <= 1'b0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      adc_l_q     <= '0;
      adc_r_q     <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      chan_q      <= chan_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      adc_l_q     <= adc_l_d;
      adc_r_q     <= adc_r_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  // TX next-state: holding register handshake and MSB-first serializer
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    tx_right_d  = tx_right_q;
    tx_sh_d     = tx_sh_q;
    dacdat_d    = dacdat_q;
    underrun_d  = 1'b0;
    tx_word     = '0;
    if (left_slot) begin
      if (hold_full_q) begin
        tx_word     = hold_l_q;
        tx_right_d  = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        tx_right_d = '0;
        underrun_d = 1'b1;
      end
      dacdat_d = tx_word[DATA_WIDTH-1];
      tx_sh_d  = {tx_word[DATA_WIDTH-2:0], 1'b0};
    end else if (right_slot) begin
      dacdat_d = tx_right_q[DATA_WIDTH-1];
      tx_sh_d  = {tx_right_q[DATA_WIDTH-2:0], 1'b0};
    end else if (bck_rise) begin
      // Zeros shift in behind the word, so DACDAT idles low after the LSB.
      dacdat_d = tx_sh_q[DATA_WIDTH-1];
      tx_sh_d  = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
    end
    // Applied after the slot load so a pair arriving on an underrun slot
    // is kept for the next frame.
    if (accept) begin
      hold_l_d    = bus.iDAC_L;
      hold_r_d    = bus.iDAC_R;
      hold_full_d = 1'b1;
    end
    ready_d = ~hold_full_d;
  end

  // TX registers
  always_ff @(posedge iCLK_18_4) begin
    if (!iRST_N) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      tx_right_q  <= '0;
      tx_sh_q     <= '0;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      tx_right_q  <= tx_right_d;
      tx_sh_q     <= tx_sh_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
    end
  end

  assign oAUD_DACDAT    = dacdat_q;
  assign bus.oADC_L     = adc_l_q;
  assign bus.oADC_R     = adc_r_q;
  assign bus.oADC_VALID = valid_q;
  assign bus.oDAC_READY = ready_q;
  assign bus.oUNDERRUN  = underrun_q;
  assign bus.oFRAME_ERR = ferr_q;

endmodule

// File: tb/tb_codec_i2s_slave.sv
// Bench for codec_i2s_slave: plays the codec side (BCLK 3 clk high/3 low,
// 64-BCLK frames), captures DACDAT on BCLK rises and scoreboards ADC pairs.
module tb_codec_i2s_slave;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bck = 1'b1;
  logic lrck = 1'b1;
  logic adcdat = 1'b0;
  logic dacdat;

  codec_i2s_slave_if #(.DATA_WIDTH(DW)) bus ();

  codec_i2s_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .iCLK_18_4  (clk),
    .iRST_N     (rst_n),
    .iAUD_BCK   (bck),
    .iAUD_LRCK  (lrck),
    .iAUD_ADCDAT(adcdat),
    .oAUD_DACDAT(dacdat),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int ur_cnt = 0;
  int fe_cnt = 0;

  logic [31:0] adc_q[$];
  logic [31:0] mon_exp;

  bit          hold_full_m = 1'b0;
  logic [15:0] hold_l_m = '0;
  logic [15:0] hold_r_m = '0;
  bit          late_offer = 1'b0;
  logic [15:0] late_l = '0;
  logic [15:0] late_r = '0;

  typedef struct {
    logic [15:0] adc_l;
    logic [15:0] adc_r;
    logic [15:0] dac_l;
    logic [15:0] dac_r;
    bit          offer;
    int          exp_ur;
    int          exp_valid;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ADC scoreboard and status pulse counters
  always @(negedge clk) begin
    if (bus.oADC_VALID === 1'b1) begin
      valid_cnt++;
      if (adc_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL adc_valid_unexpected: got L=%h R=%h expected no pulse",
                 bus.oADC_L, bus.oADC_R);
      end else begin
        mon_exp = adc_q.pop_front();
        check("adc_pair", {bus.oADC_L, bus.oADC_R}, mon_exp);
      end
    end
    if (bus.oUNDERRUN === 1'b1) ur_cnt++;
    if (bus.oFRAME_ERR === 1'b1) fe_cnt++;
  end

  // Holding-register model applied at each left delay slot
  task automatic tx_model(output logic [15:0] l, output logic [15:0] r);
    if (hold_full_m) begin
      l = hold_l_m;
      r = hold_r_m;
      hold_full_m = 1'b0;
    end else begin
      l = '0;
      r = '0;
    end
  endtask

  // One LRCK half: slot bit then nbits-1 data/pad bits; codec samples DACDAT on BCLK rise
  task automatic drive_half(input bit lr, input logic [15:0] word, input int nbits,
                            input bit chk, input logic [15:0] exp_dac);
    logic [15:0] cap;
    bit          tail_bad;
    cap = '0;
    tail_bad = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      bck = 1'b0;
      lrck = lr;
      adcdat = (k >= 1 && k <= DW) ? word[DW-k] : 1'b0;
      if (late_offer && !lr && k == 1) begin
        check("ready_drop_late_accept", {31'b0, bus.oDAC_READY}, 32'd0);
        bus.iDAC_VALID = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      if (k >= 1 && k <= DW) cap[DW-k] = dacdat;
      else if (k > DW && dacdat !== 1'b0) tail_bad = 1'b1;
      bck = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (late_offer && !lr && k == 0) begin
        bus.iDAC_L = late_l;
        bus.iDAC_R = late_r;
        bus.iDAC_VALID = 1'b1;
      end
    end
    if (chk) begin
      check(lr ? "dac_right_word" : "dac_left_word", {16'b0, cap}, {16'b0, exp_dac});
      check("dac_tail_zero", {31'b0, tail_bad}, 32'd0);
    end
  endtask

  task automatic drive_frame(input logic [15:0] al, input logic [15:0] ar, input bit push);
    logic [15:0] txl, txr;
    bit late;
    tx_model(txl, txr);
    late = late_offer;
    if (push) adc_q.push_back({al, ar});
    drive_half(1'b0, al, 32, 1'b1, txl);
    if (late) begin
      hold_full_m = 1'b1;
      hold_l_m = late_l;
      hold_r_m = late_r;
      late_offer = 1'b0;
    end
    check("ready_after_left_slot", {31'b0, bus.oDAC_READY}, {31'b0, !hold_full_m});
    drive_half(1'b1, ar, 32, 1'b1, txr);
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    bit done;
    done = 1'b0;
    @(negedge clk);
    bus.iDAC_L = l;
    bus.iDAC_R = r;
    bus.iDAC_VALID = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.oDAC_READY === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    bus.iDAC_VALID = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL offer_timeout: got oDAC_READY low for 20 cycles expected high");
    end else begin
      check("ready_drop_after_accept", {31'b0, bus.oDAC_READY}, 32'd0);
      hold_full_m = 1'b1;
      hold_l_m = l;
      hold_r_m = r;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adc_l"}, {16'b0, bus.oADC_L}, 32'd0);
    check({tag, "_adc_r"}, {16'b0, bus.oADC_R}, 32'd0);
    check({tag, "_adc_valid"}, {31'b0, bus.oADC_VALID}, 32'd0);
    check({tag, "_dacdat"}, {31'b0, dacdat}, 32'd0);
    check({tag, "_underrun"}, {31'b0, bus.oUNDERRUN}, 32'd0);
    check({tag, "_frame_err"}, {31'b0, bus.oFRAME_ERR}, 32'd0);
    check({tag, "_dac_ready"}, {31'b0, bus.oDAC_READY}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1000000 expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, f0, v0;
    logic [15:0] txl, txr;

    tbl[0] = '{16'hA5C3, 16'h0F1E, 16'h0000, 16'h0000, 1'b0, 1, 1};
    tbl[1] = '{16'hA5C3, 16'h0F1E, 16'h8001, 16'h7FFE, 1'b1, 0, 1};
    tbl[2] = '{16'hA5C3, 16'h0F1E, 16'h0000, 16'h0000, 1'b0, 1, 1};
    tbl[3] = '{16'h1234, 16'hFEDC, 16'h0000, 16'hFFFF, 1'b1, 0, 1};
    tbl[4] = '{16'hFFFF, 16'h0001, 16'h5A5A, 16'h8000, 1'b1, 0, 1};
    tbl[5] = '{16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1, 1};

    bus.iDAC_L = '0;
    bus.iDAC_R = '0;
    bus.iDAC_VALID = 1'b0;

    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'b0, bus.oDAC_READY}, 32'd1);

    drive_half(1'b1, 16'h0000, 4, 1'b0, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].offer) offer(tbl[i].dac_l, tbl[i].dac_r);
      u0 = ur_cnt; f0 = fe_cnt; v0 = valid_cnt;
      drive_frame(tbl[i].adc_l, tbl[i].adc_r, 1'b1);
      check("underrun_per_frame", ur_cnt - u0, tbl[i].exp_ur);
      check("frame_err_clean", fe_cnt - f0, 32'd0);
      check("valid_per_frame", valid_cnt - v0, tbl[i].exp_valid);
    end

    // LRCK toggles after 10 bits of a right word
    f0 = fe_cnt; v0 = valid_cnt;
    tx_model(txl, txr);
    drive_half(1'b0, 16'h1111, 32, 1'b1, txl);
    drive_half(1'b1, 16'h2222, 11, 1'b0, 16'h0000);
    check("valid_after_short_right", valid_cnt - v0, 32'd0);
    drive_frame(16'h3333, 16'h4444, 1'b1);
    check("frame_err_single", fe_cnt - f0, 32'd1);
    check("valid_after_recovery", valid_cnt - v0, 32'd1);

    // Two short words in a row: stale left word must not pair with a right
    f0 = fe_cnt; v0 = valid_cnt;
    tx_model(txl, txr);
    drive_half(1'b0, 16'h5555, 32, 1'b0, 16'h0000);
    drive_half(1'b1, 16'h6666, 11, 1'b0, 16'h0000);
    tx_model(txl, txr);
    drive_half(1'b0, 16'h7777, 11, 1'b0, 16'h0000);
    drive_half(1'b1, 16'h8888, 32, 1'b0, 16'h0000);
    check("frame_err_double", fe_cnt - f0, 32'd2);
    check("valid_suppressed", valid_cnt - v0, 32'd0);
    drive_frame(16'h9ABC, 16'hDEF0, 1'b1);
    check("valid_after_double", valid_cnt - v0, 32'd1);

    // Reset mid-left-word with a pair held
    tx_model(txl, txr);
    drive_half(1'b0, 16'hBEEF, 8, 1'b0, 16'h0000);
    offer(16'hDEAD, 16'hBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    hold_full_m = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", {31'b0, bus.oDAC_READY}, 32'd1);
    v0 = valid_cnt; u0 = ur_cnt; f0 = fe_cnt;
    drive_half(1'b1, 16'h7777, 32, 1'b1, 16'h0000);
    check("no_valid_right_only", valid_cnt - v0, 32'd0);
    drive_frame(16'hC0DE, 16'h1357, 1'b1);
    check("valid_after_midreset", valid_cnt - v0, 32'd1);
    check("underrun_after_midreset", ur_cnt - u0, 32'd1);
    check("no_frame_err_midreset", fe_cnt - f0, 32'd0);

    // Pair offered in the same cycle as an underrunning left slot
    late_l = 16'h3C5A;
    late_r = 16'hC3A5;
    late_offer = 1'b1;
    u0 = ur_cnt;
    drive_frame(16'h2468, 16'h1357, 1'b1);
    check("underrun_late_offer", ur_cnt - u0, 32'd1);
    u0 = ur_cnt;
    drive_frame(16'h0F0F, 16'hF0F0, 1'b1);
    check("late_pair_no_underrun", ur_cnt - u0, 32'd0);

    repeat (10) @(negedge clk);
    check("adc_queue_drained", adc_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/codec_i2s_slave.md
Name: codec_i2s_slave

Overview:
- I2S slave-mode audio interface for the WM8731 when the codec is I2S master: the codec drives BCLK and LRCK, and this block follows them.
- Oversamples BCLK, LRCK and ADCDAT in the 18.432 MHz system domain.
- Deserializes ADC left/right words into a parallel sample pair with a valid strobe.
- Serializes a DAC sample pair, supplied through a ready/valid handshake, onto DACDAT.

Parameters:
- DATA_WIDTH, 16, bits per channel word (MSB first).
- SYNC_STAGES, 2, flip-flop stages on each audio input pin (minimum 2).

Ports:
- iCLK_18_4  in  1  system clock, 18.432 MHz.
- iRST_N  in  1  reset, synchronous, active-low.
- iAUD_BCK  in  1  bit clock from the codec.
- iAUD_LRCK  in  1  word select from the codec; low = left, high = right.
- iAUD_ADCDAT  in  1  serial ADC data from the codec.
- oAUD_DACDAT  out  1  serial DAC data to the codec.
- oADC_L  out  DATA_WIDTH  last complete left ADC word.
- oADC_R  out  DATA_WIDTH  last complete right ADC word.
- oADC_VALID  out  1  one-cycle pulse; new oADC_L/oADC_R pair is valid.
- iDAC_L  in  DATA_WIDTH  left DAC word.
- iDAC_R  in  DATA_WIDTH  right DAC word.
- iDAC_VALID  in  1  DAC pair offered.
- oDAC_READY  out  1  holding register empty; pair accepted when iDAC_VALID && oDAC_READY.
- oUNDERRUN  out  1  one-cycle pulse; left frame started with no DAC pair held.
- oFRAME_ERR  out  1  one-cycle pulse; LRCK changed before DATA_WIDTH bits were received.

Behaviour:
- Interface: iCLK_18_4 is the only clock; iRST_N is synchronous and active-low. Nothing else is clocked: BCLK is treated as data.
- Input synchronisation and edge detection:
  - SYNC_STAGES-flop synchronizers on iAUD_BCK, iAUD_LRCK and iAUD_ADCDAT.
  - bck_rise / bck_fall are one-cycle pulses from the synchronized BCLK versus its previous value.
  - Requirement: BCLK high and low times are each at least 3 iCLK cycles (3.072 MHz BCLK is supported).
- Slot detection: on each bck_rise, sample LRCK into lr_prev.
  - A bck_rise where the synchronized LRCK differs from lr_prev is the I2S delay slot.
  - The MSB follows on the next bck_rise.
- RX state machine (advances only on bck_rise):
  - IDLE: after reset, wait for the first delay slot, then go to SHIFT. Any partial frame is discarded.
  - SHIFT: shift ADCDAT into the shift register MSB-first, with bit_cnt 0..DATA_WIDTH-1.
    - At bit_cnt = DATA_WIDTH-1, store the word to the left holding register (LRCK low) or to oADC_R (LRCK high), then go to WAIT.
    - On the right-word store, copy the left holding register to oADC_L and pulse oADC_VALID on the next cycle, only if a left word completed since the last valid.
  - WAIT: ignore extra bits (e.g. 32-bit slots); a delay slot returns to SHIFT.
  - Delay slot while in SHIFT: pulse oFRAME_ERR, discard the partial word, restart SHIFT for the new channel, and suppress oADC_VALID for that frame.
- RX latency: oADC_VALID rises no later than SYNC_STAGES+2 iCLK cycles after the pin-level BCLK rising edge that carries the right LSB.
- TX holding register (one pair):
  - Handshake: accept when iDAC_VALID && oDAC_READY; oDAC_READY drops on the next cycle.
  - Left delay slot with the holding register full: load the pair into tx_left/tx_right, free the holding register; oDAC_READY rises on the next cycle.
  - Left delay slot with the holding register empty: load zeros into both channels and pulse oUNDERRUN. A pair accepted in that same cycle is kept for the next frame.
- TX serializer:
  - At a delay slot, drive the MSB of the channel word (left or right by new LRCK) on the next cycle.
  - On each following bck_rise, drive the next bit.
  - After the LSB, drive 0 until the next delay slot.
  - DACDAT therefore changes about half a BCLK period before the codec's sampling rising edge.
- Reset (iRST_N low at a clock edge):
  - All outputs are 0: oADC_L, oADC_R, oADC_VALID, oAUD_DACDAT, oUNDERRUN, oFRAME_ERR, oDAC_READY.
  - The holding register is emptied and RX returns to IDLE.
  - oDAC_READY is 1 on the first cycle after reset releases.
  - TX drives 0 until the first left delay slot.
  - Reset asserted mid-frame abandons the frame without any error pulse.

Test Plan:
- 64-BCLK frames at 3.072 MHz, ADC left=16'hA5C3, right=16'h0F1E -> one oADC_VALID pulse per frame with oADC_L=A5C3 and oADC_R=0F1E; no oFRAME_ERR.
- DAC pair L=16'h8001, R=16'h7FFE accepted before a left slot -> DACDAT bit stream checked against codec-side sampling on BCLK rise; oDAC_READY low then high at the left slot; no underrun.
- No DAC pair offered -> oUNDERRUN pulses once per frame; DACDAT is all zeros.
- LRCK toggled after 10 bits of a right word -> one oFRAME_ERR pulse; no oADC_VALID that frame; the next clean frame is valid.
- Reset asserted mid-left-word, then released -> all outputs 0; the first oADC_VALID occurs only after a complete left+right frame.
- iDAC_VALID rises in the same cycle as a left slot with the holding register empty -> oUNDERRUN pulses; the pair is transmitted in the following frame.
